// File: rtl/frame_timer_gen2.sv
// -----------------------------------------------------------------------------
// frame_timer_gen2
//
// Purpose:
//   Frame-count timer for the game level. Counts rising edges of the per-frame
//   strobe (i_new_frame) in the system clock domain. It provides a runtime
//   terminal count, pause/resume, abort (clear), restart from DONE, and a
//   periodic mark pulse (e.g. one per second of frames). The un_time count
//   feeds the note scheduler. stop_sign tells the game FSM that the level is over.
//
// Optional feature (macro FRAME_TIMER_LOOP_EN):
//   When defined, reaching the terminal count wraps un_time to 0 and stays in
//   RUN, pulsing done each lap. DONE is then unreachable and stop_sign stays 0.
//   When undefined, the timer stops in DONE and holds the terminal count.
//
// Parameters:
//   WIDTH       - width of un_time / end_count
//   MARK_PERIOD - counted frames per mark pulse (1 .. 2^WIDTH-1)
//   MARK_W      - width of the mark counter (wraps)
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous active-high reset
//   i_new_frame   frame strobe (level); only its rising edge counts
//   i_start_sign  start from IDLE, restart from DONE
//   i_pause_sign  level; high holds the count
//   i_clear_sign  functional abort back to IDLE
//   i_end_count   terminal count, latched on start (0 means all ones)
//   o_un_time     frames elapsed
//   o_stop_sign   high while in DONE
//   o_done_pulse  one-cycle pulse on reaching the terminal count
//   o_running     high in RUN
//   o_paused      high in PAUSE
//   o_mark_pulse  one-cycle pulse every MARK_PERIOD counted frames
//   o_mark_cnt    marks since start
// -----------------------------------------------------------------------------
module frame_timer_gen2 #(
    parameter int WIDTH       = 16,
    parameter int MARK_PERIOD = 60,
    parameter int MARK_W      = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_new_frame,
    input  logic               i_start_sign,
    input  logic               i_pause_sign,
    input  logic               i_clear_sign,
    input  logic [WIDTH-1:0]   i_end_count,
    output logic [WIDTH-1:0]   o_un_time,
    output logic               o_stop_sign,
    output logic               o_done_pulse,
    output logic               o_running,
    output logic               o_paused,
    output logic               o_mark_pulse,
    output logic [MARK_W-1:0]  o_mark_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]  W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]  W_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  W_ONES  = {WIDTH{1'b1}};
    localparam logic [MARK_W-1:0] M_ONE   = {{(MARK_W-1){1'b0}}, 1'b1};
    localparam logic [MARK_W-1:0] M_ZERO  = {MARK_W{1'b0}};
    localparam logic [WIDTH-1:0]  SUB_TOP = WIDTH'(MARK_PERIOD - 1);

    state_t              r_state;
    logic                r_nf_q;
    logic [WIDTH-1:0]    r_un_time;
    logic [WIDTH-1:0]    r_end_lat;
    logic [WIDTH-1:0]    r_sub_cnt;
    logic [MARK_W-1:0]   r_mark_cnt;
    logic                r_done_pulse;
    logic                r_mark_pulse;
    logic                r_stop;
    logic                r_running;
    logic                r_paused;

    logic                w_tick;
    logic                w_end_hit;
    logic                w_mark_hit;
    logic [WIDTH-1:0]    w_end_load;

    // Edge detect, terminal/mark compares and the end-count value to latch.
    always_comb begin
        w_tick     = i_new_frame & ~r_nf_q;
        w_end_hit  = (r_un_time == (r_end_lat - W_ONE));
        w_mark_hit = (r_sub_cnt == SUB_TOP);
        if (i_end_count == W_ZERO) begin
            w_end_load = W_ONES;
        end else begin
            w_end_load = i_end_count;
        end
    end

    // Timer FSM with all counters and registered status/pulse outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_nf_q       <= 1'b1;   // a strobe held high across release is not a tick
            r_un_time    <= W_ZERO;
            r_end_lat    <= W_ONES;
            r_sub_cnt    <= W_ZERO;
            r_mark_cnt   <= M_ZERO;
            r_done_pulse <= 1'b0;
            r_mark_pulse <= 1'b0;
            r_stop       <= 1'b0;
            r_running    <= 1'b0;
            r_paused     <= 1'b0;
        end else begin
            r_nf_q       <= i_new_frame;
            r_done_pulse <= 1'b0;
            r_mark_pulse <= 1'b0;
            if (i_clear_sign) begin
                r_state    <= S_IDLE;
                r_un_time  <= W_ZERO;
                r_sub_cnt  <= W_ZERO;
                r_mark_cnt <= M_ZERO;
                r_stop     <= 1'b0;
                r_running  <= 1'b0;
                r_paused   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_un_time <= W_ZERO;
                        if (i_start_sign) begin
                            r_state    <= S_RUN;
                            r_sub_cnt  <= W_ZERO;
                            r_mark_cnt <= M_ZERO;
                            r_end_lat  <= w_end_load;
                            r_running  <= 1'b1;
                        end else begin
                            r_state    <= S_IDLE;
                        end
                    end
                    S_RUN: begin
                        // Pause has priority: a tick on the same edge is dropped.
                        if (i_pause_sign) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                            r_paused  <= 1'b1;
                        end else if (w_tick) begin
                            if (w_end_hit) begin
                                r_done_pulse <= 1'b1;
`ifdef FRAME_TIMER_LOOP_EN
                                r_un_time    <= W_ZERO;
`else
                                r_un_time    <= r_end_lat;
                                r_state      <= S_DONE;
                                r_running    <= 1'b0;
                                r_stop       <= 1'b1;
`endif
                            end else begin
                                r_un_time <= r_un_time + W_ONE;
                            end
                            if (w_mark_hit) begin
                                r_sub_cnt    <= W_ZERO;
                                r_mark_pulse <= 1'b1;
                                r_mark_cnt   <= r_mark_cnt + M_ONE;
                            end else begin
                                r_sub_cnt    <= r_sub_cnt + W_ONE;
                            end
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                    S_PAUSE: begin
                        if (!i_pause_sign) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                            r_paused  <= 1'b0;
                        end else begin
                            r_state   <= S_PAUSE;
                        end
                    end
                    S_DONE: begin
                        if (i_start_sign) begin
                            r_state    <= S_RUN;
                            r_un_time  <= W_ZERO;
                            r_sub_cnt  <= W_ZERO;
                            r_mark_cnt <= M_ZERO;
                            r_end_lat  <= w_end_load;
                            r_stop     <= 1'b0;
                            r_running  <= 1'b1;
                        end else begin
                            r_state    <= S_DONE;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_un_time  <= W_ZERO;
                        r_sub_cnt  <= W_ZERO;
                        r_mark_cnt <= M_ZERO;
                        r_stop     <= 1'b0;
                        r_running  <= 1'b0;
                        r_paused   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_un_time    = r_un_time;
    assign o_stop_sign  = r_stop;
    assign o_done_pulse = r_done_pulse;
    assign o_running    = r_running;
    assign o_paused     = r_paused;
    assign o_mark_pulse = r_mark_pulse;
    assign o_mark_cnt   = r_mark_cnt;

endmodule
